// File: rtl/conv_sched_pkg.sv
// Layer constants, derived address widths and shared types for the conv2d
// scheduler and its tap delay line.
package conv_pkg;

   localparam int unsigned IN_H   = 227;
   localparam int unsigned IN_W   = 227;
   localparam int unsigned K      = 11;
   localparam int unsigned STRIDE = 4;
   localparam int unsigned OUT_H  = 55;
   localparam int unsigned OUT_W  = 55;

   localparam int unsigned ROW_W  = $clog2(IN_H);
   localparam int unsigned COL_W  = $clog2(IN_W);
   localparam int unsigned KIDX_W = $clog2(K * K);
   localparam int unsigned OROW_W = $clog2(OUT_H);
   localparam int unsigned OCOL_W = $clog2(OUT_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } conv_state_e;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tap_t;

endpackage

// File: rtl/conv_sched_tap_pipe.sv
// DEPTH-stage delay line for {valid, first, last} tap markers, cleared by
// reset or a synchronous clear.
module conv_tap_pipe
   import conv_pkg::*;
#(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  tap_t tap_i,
   output tap_t tap_o
);

   tap_t stage_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (clr_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= tap_i;
         for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign tap_o = stage_q[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// Raster-order scheduler for a single-MAC stride conv2d: issues buffer/ROM
// reads per tap, aligns accumulator controls and hands off each result.
module conv_sched #(
   parameter int unsigned IN_H   = conv_pkg::IN_H,
   parameter int unsigned IN_W   = conv_pkg::IN_W,
   parameter int unsigned K      = conv_pkg::K,
   parameter int unsigned STRIDE = conv_pkg::STRIDE,
   parameter int unsigned OUT_H  = conv_pkg::OUT_H,
   parameter int unsigned OUT_W  = conv_pkg::OUT_W,
   parameter int unsigned RD_LAT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   output logic                     busy,
   output logic                     done,
   output logic                     in_rd_en,
   output logic [$clog2(IN_H)-1:0]  in_rd_row,
   output logic [$clog2(IN_W)-1:0]  in_rd_col,
   output logic                     k_rd_en,
   output logic [$clog2(K*K)-1:0]   k_rd_idx,
   output logic                     mac_en,
   output logic                     mac_clr,
   output logic                     mac_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(OUT_H)-1:0] out_row,
   output logic [$clog2(OUT_W)-1:0] out_col
);
   import conv_pkg::*;

   localparam int unsigned RW  = $clog2(IN_H);
   localparam int unsigned CW  = $clog2(IN_W);
   localparam int unsigned IW  = $clog2(K * K);
   localparam int unsigned OYW = $clog2(OUT_H);
   localparam int unsigned OXW = $clog2(OUT_W);
   localparam int unsigned MW  = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned DW  = $clog2(RD_LAT + 1);

   localparam logic [MW-1:0]  K_LAST  = MW'(K - 1);
   localparam logic [RW-1:0]  STEP_R  = RW'(STRIDE);
   localparam logic [CW-1:0]  STEP_C  = CW'(STRIDE);
   localparam logic [OYW-1:0] OY_LAST = OYW'(OUT_H - 1);
   localparam logic [OXW-1:0] OX_LAST = OXW'(OUT_W - 1);
   localparam logic [DW-1:0]  DR_LAST = DW'(RD_LAT);

   if ((OUT_H - 1) * STRIDE + K > IN_H || (OUT_W - 1) * STRIDE + K > IN_W) begin : g_bad_geometry
      $error("conv_sched: output geometry does not fit the input");
   end

   conv_state_e    state_q;
   logic [OYW-1:0] oy_q;
   logic [OXW-1:0] ox_q;
   logic [MW-1:0]  m_q, n_q;
   logic [RW-1:0]  row_base_q, rd_row_q;
   logic [CW-1:0]  col_base_q, rd_col_q;
   logic [IW-1:0]  kidx_q;
   logic [DW-1:0]  drain_q;
   logic           rd_en_q, out_valid_q, busy_q, done_q;
   tap_t           tap_d, tap_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         oy_q        <= '0;
         ox_q        <= '0;
         m_q         <= '0;
         n_q         <= '0;
         row_base_q  <= '0;
         col_base_q  <= '0;
         rd_row_q    <= '0;
         rd_col_q    <= '0;
         kidx_q      <= '0;
         drain_q     <= '0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (abort) begin
         state_q     <= S_IDLE;
         oy_q        <= '0;
         ox_q        <= '0;
         m_q         <= '0;
         n_q         <= '0;
         row_base_q  <= '0;
         col_base_q  <= '0;
         rd_row_q    <= '0;
         rd_col_q    <= '0;
         kidx_q      <= '0;
         drain_q     <= '0;
         rd_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_ISSUE;
                  oy_q       <= '0;
                  ox_q       <= '0;
                  m_q        <= '0;
                  n_q        <= '0;
                  row_base_q <= '0;
                  col_base_q <= '0;
                  rd_row_q   <= '0;
                  rd_col_q   <= '0;
                  kidx_q     <= '0;
                  rd_en_q    <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_ISSUE: begin
               // Final tap leaves every counter at its terminal value.
               if (n_q != K_LAST) begin
                  n_q      <= n_q + MW'(1);
                  rd_col_q <= rd_col_q + CW'(1);
                  kidx_q   <= kidx_q + IW'(1);
               end else if (m_q != K_LAST) begin
                  n_q      <= '0;
                  m_q      <= m_q + MW'(1);
                  rd_col_q <= col_base_q;
                  rd_row_q <= rd_row_q + RW'(1);
                  kidx_q   <= kidx_q + IW'(1);
               end else begin
                  state_q <= S_DRAIN;
                  rd_en_q <= 1'b0;
                  drain_q <= '0;
               end
            end
            S_DRAIN: begin
               if (drain_q == DR_LAST) begin
                  state_q     <= S_WRITE;
                  out_valid_q <= 1'b1;
               end else begin
                  drain_q <= drain_q + DW'(1);
               end
            end
            S_WRITE: begin
               if (out_ready) begin
                  // Next-window defaults first; the final branch overrides them.
                  out_valid_q <= 1'b0;
                  state_q     <= S_ISSUE;
                  rd_en_q     <= 1'b1;
                  m_q         <= '0;
                  n_q         <= '0;
                  kidx_q      <= '0;
                  rd_row_q    <= row_base_q;
                  if (ox_q != OX_LAST) begin
                     ox_q       <= ox_q + OXW'(1);
                     col_base_q <= col_base_q + STEP_C;
                     rd_col_q   <= col_base_q + STEP_C;
                  end else if (oy_q != OY_LAST) begin
                     ox_q       <= '0;
                     oy_q       <= oy_q + OYW'(1);
                     col_base_q <= '0;
                     rd_col_q   <= '0;
                     row_base_q <= row_base_q + STEP_R;
                     rd_row_q   <= row_base_q + STEP_R;
                  end else begin
                     state_q  <= S_DONE;
                     rd_en_q  <= 1'b0;
                     rd_row_q <= rd_row_q;
                     done_q   <= 1'b1;
                     busy_q   <= 1'b0;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      tap_d       = '0;
      tap_d.valid = rd_en_q;
      tap_d.first = rd_en_q && (kidx_q == '0);
      tap_d.last  = rd_en_q && (m_q == K_LAST) && (n_q == K_LAST);
   end

   conv_tap_pipe #(
      .DEPTH (RD_LAT)
   ) u_tap_pipe (
      .clk   (clk),
      .rst   (rst),
      .clr_i (abort),
      .tap_i (tap_d),
      .tap_o (tap_q)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_rd_en  = rd_en_q;
   assign k_rd_en   = rd_en_q;
   assign in_rd_row = rd_row_q;
   assign in_rd_col = rd_col_q;
   assign k_rd_idx  = kidx_q;
   assign mac_en    = tap_q.valid;
   assign mac_clr   = tap_q.first;
   assign mac_last  = tap_q.last;
   assign out_valid = out_valid_q;
   assign out_row   = oy_q;
   assign out_col   = ox_q;

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: a default-geometry instance for addressing, backpressure,
// abort and reset, and a small instance for complete-layer runs.
module tb_conv_sched;

   localparam int DK = 11, DL = 1;
   localparam int SK = 3, SL = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic       d_start, d_abort, d_ready;
   logic       d_busy, d_done, d_rd_en, d_k_en, d_mac_en, d_mac_clr, d_mac_last, d_valid;
   logic [7:0] d_row, d_col;
   logic [6:0] d_kidx;
   logic [5:0] d_orow, d_ocol;
   logic [7:0] d_ctl;
   logic [42:0] d_all;

   logic       s_start, s_abort, s_ready;
   logic       s_busy, s_done, s_rd_en, s_k_en, s_mac_en, s_mac_clr, s_mac_last, s_valid;
   logic [3:0] s_row, s_col, s_kidx;
   logic [1:0] s_orow, s_ocol;
   logic [7:0] s_ctl;
   logic [23:0] s_all;

   int n_cmp, n_bad;

   assign d_ctl = {d_busy, d_done, d_rd_en, d_k_en, d_mac_en, d_mac_clr, d_mac_last, d_valid};
   assign d_all = {d_ctl, d_row, d_col, d_kidx, d_orow, d_ocol};
   assign s_ctl = {s_busy, s_done, s_rd_en, s_k_en, s_mac_en, s_mac_clr, s_mac_last, s_valid};
   assign s_all = {s_ctl, s_row, s_col, s_kidx, s_orow, s_ocol};

   conv_sched dut_d (
      .clk(clk), .rst(rst), .start(d_start), .abort(d_abort),
      .busy(d_busy), .done(d_done),
      .in_rd_en(d_rd_en), .in_rd_row(d_row), .in_rd_col(d_col),
      .k_rd_en(d_k_en), .k_rd_idx(d_kidx),
      .mac_en(d_mac_en), .mac_clr(d_mac_clr), .mac_last(d_mac_last),
      .out_valid(d_valid), .out_ready(d_ready), .out_row(d_orow), .out_col(d_ocol)
   );

   conv_sched #(
      .IN_H(11), .IN_W(11), .K(3), .STRIDE(4), .OUT_H(3), .OUT_W(3), .RD_LAT(2)
   ) dut_s (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
      .busy(s_busy), .done(s_done),
      .in_rd_en(s_rd_en), .in_rd_row(s_row), .in_rd_col(s_col),
      .k_rd_en(s_k_en), .k_rd_idx(s_kidx),
      .mac_en(s_mac_en), .mac_clr(s_mac_clr), .mac_last(s_mac_last),
      .out_valid(s_valid), .out_ready(s_ready), .out_row(s_orow), .out_col(s_ocol)
   );

   task automatic test_reset();
      rst = 1'b1;
      d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b0;
      s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
      #1;
      n_cmp++; if (d_all !== 43'd0) begin n_bad++; $display("FAIL reset_d: got %h want 0", d_all); end
      n_cmp++; if (s_all !== 24'd0) begin n_bad++; $display("FAIL reset_s: got %h want 0", s_all); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (d_all !== 43'd0) begin n_bad++; $display("FAIL idle_d: got %h want 0", d_all); end
      n_cmp++; if (s_all !== 24'd0) begin n_bad++; $display("FAIL idle_s: got %h want 0", s_all); end
   endtask

   // Window (0,0) cycle by cycle: taps in raster order, MAC controls RD_LAT later.
   task automatic test_first_window();
      bit iss, mac;
      int t;
      logic [7:0] exp_ctl;
      logic [22:0] exp_adr;
      d_ready = 1'b1;
      d_start = 1'b1;
      @(negedge clk);
      d_start = 1'b0;
      for (int c = 0; c <= DK*DK + DL + 1; c++) begin
         iss = (c < DK*DK);
         t = c - DL;
         mac = (t >= 0) && (t < DK*DK);
         exp_ctl = {1'b1, 1'b0, iss, iss, mac, mac && (t == 0), mac && (t == DK*DK-1),
                    c == DK*DK + DL + 1};
         n_cmp++;
         if (d_ctl !== exp_ctl) begin
            n_bad++; $display("FAIL first_win_ctl c=%0d: got %b want %b", c, d_ctl, exp_ctl);
         end
         if (iss) begin
            exp_adr = {8'(c / DK), 8'(c % DK), 7'(c)};
            n_cmp++;
            if ({d_row, d_col, d_kidx} !== exp_adr) begin
               n_bad++; $display("FAIL first_win_addr c=%0d: got %h want %h", c, {d_row, d_col, d_kidx}, exp_adr);
            end
         end
         if (c < DK*DK + DL + 1) @(negedge clk);
      end
      n_cmp++;
      if ({d_orow, d_ocol} !== 12'd0) begin
         n_bad++; $display("FAIL first_win_out: got %h want 0", {d_orow, d_ocol});
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      @(negedge clk);
      d_ready = 1'b0;
      n_cmp++;
      if ({d_rd_en, d_row, d_col, d_kidx} !== {1'b1, 8'd0, 8'd4, 7'd0}) begin
         n_bad++; $display("FAIL bp_next_window: got %h want %h", {d_rd_en, d_row, d_col, d_kidx}, {1'b1, 8'd0, 8'd4, 7'd0});
      end
      cyc = 0;
      while (!d_valid && cyc < 400) begin @(negedge clk); cyc++; end
      n_cmp++;
      if (cyc != DK*DK + DL + 1) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", cyc, DK*DK + DL + 1); end
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if ({d_valid, d_rd_en, d_orow, d_ocol} !== {1'b1, 1'b0, 6'd0, 6'd1}) begin
            n_bad++; $display("FAIL bp_hold i=%0d: got %h want %h", i, {d_valid, d_rd_en, d_orow, d_ocol}, {1'b1, 1'b0, 6'd0, 6'd1});
         end
         @(negedge clk);
      end
      d_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({d_valid, d_rd_en, d_row, d_col, d_kidx} !== {1'b0, 1'b1, 8'd0, 8'd8, 7'd0}) begin
         n_bad++; $display("FAIL bp_resume: got %h want %h", {d_valid, d_rd_en, d_row, d_col, d_kidx}, {1'b0, 1'b1, 8'd0, 8'd8, 7'd0});
      end
   endtask

   // Random ready until window (2,5) tap 37, then abort and restart.
   task automatic test_abort();
      int ey, ex, cyc, dones;
      bit found;
      ey = 0; ex = 2; cyc = 0; found = 1'b0;
      while (!found && cyc < 30000) begin
         d_ready = ($urandom_range(0, 3) != 0);
         if (d_valid && d_ready) begin
            n_cmp++;
            if ({d_orow, d_ocol} !== {6'(ey), 6'(ex)}) begin
               n_bad++; $display("FAIL raster_order: got (%0d,%0d) want (%0d,%0d)", d_orow, d_ocol, ey, ex);
            end
            if (ex == 54) begin ex = 0; ey++; end else ex++;
         end
         if (ey == 2 && ex == 5 && d_rd_en && d_kidx == 7'd37) found = 1'b1;
         else begin @(negedge clk); cyc++; end
      end
      n_cmp++;
      if (!found) begin
         n_bad++; $display("FAIL abort_reach: got timeout want window (2,5) tap 37");
      end else begin
         n_cmp++;
         if ({d_row, d_col} !== {8'd11, 8'd24}) begin
            n_bad++; $display("FAIL abort_tap_addr: got %h want %h", {d_row, d_col}, {8'd11, 8'd24});
         end
         d_abort = 1'b1;
         @(negedge clk);
         d_abort = 1'b0;
         n_cmp++;
         if (d_ctl !== 8'd0) begin n_bad++; $display("FAIL abort_idle: got %b want 0", d_ctl); end
         dones = 0;
         for (int i = 0; i < 5; i++) begin
            dones += int'(d_done) + int'(d_busy);
            @(negedge clk);
         end
         n_cmp++;
         if (dones != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
         d_start = 1'b1;
         @(negedge clk);
         d_start = 1'b0;
         n_cmp++;
         if ({d_busy, d_rd_en, d_row, d_col, d_kidx} !== {1'b1, 1'b1, 8'd0, 8'd0, 7'd0}) begin
            n_bad++; $display("FAIL abort_restart: got %h want %h", {d_busy, d_rd_en, d_row, d_col, d_kidx}, {1'b1, 1'b1, 8'd0, 8'd0, 7'd0});
         end
      end
   endtask

   // Start during ISSUE is ignored; then async reset lands mid-DRAIN.
   task automatic test_restart_reset();
      for (int c = 0; c < DK*DK; c++) begin
         n_cmp++;
         if ({d_rd_en, d_kidx} !== {1'b1, 7'(c)}) begin
            n_bad++; $display("FAIL issue_start_ignored c=%0d: got %h want %h", c, {d_rd_en, d_kidx}, {1'b1, 7'(c)});
         end
         d_start = (c == 5);
         @(negedge clk);
      end
      d_start = 1'b0;
      n_cmp++;
      if ({d_busy, d_rd_en, d_mac_en, d_mac_last} !== 4'b1011) begin
         n_bad++; $display("FAIL drain_entry: got %b want 1011", {d_busy, d_rd_en, d_mac_en, d_mac_last});
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (d_all !== 43'd0) begin n_bad++; $display("FAIL async_rst: got %h want 0", d_all); end
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      n_cmp++;
      if (d_all !== 43'd0) begin n_bad++; $display("FAIL rst_stays_idle: got %h want 0", d_all); end
   endtask

   // Full small layer with random backpressure per output.
   task automatic test_small_full();
      int oy, ox, t, stall, busy_cnt, exp_busy, dones;
      bit iss, mac;
      logic [7:0] exp_ctl;
      logic [11:0] exp_adr;
      busy_cnt = 0; exp_busy = 0; dones = 0;
      s_ready = 1'b0;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int w = 0; w < 9; w++) begin
         oy = w / 3; ox = w % 3;
         for (int c = 0; c < SK*SK + SL + 1; c++) begin
            iss = (c < SK*SK);
            t = c - SL;
            mac = (t >= 0) && (t < SK*SK);
            exp_ctl = {1'b1, 1'b0, iss, iss, mac, mac && (t == 0), mac && (t == SK*SK-1), 1'b0};
            n_cmp++;
            if (s_ctl !== exp_ctl) begin
               n_bad++; $display("FAIL small_ctl w=%0d c=%0d: got %b want %b", w, c, s_ctl, exp_ctl);
            end
            if (iss) begin
               exp_adr = {4'(oy*4 + c/SK), 4'(ox*4 + c%SK), 4'(c)};
               n_cmp++;
               if ({s_row, s_col, s_kidx} !== exp_adr) begin
                  n_bad++; $display("FAIL small_addr w=%0d c=%0d: got %h want %h", w, c, {s_row, s_col, s_kidx}, exp_adr);
               end
            end
            s_start = (w == 4 && c == 2);
            busy_cnt += int'(s_busy); dones += int'(s_done);
            @(negedge clk);
         end
         s_start = 1'b0;
         stall = (w == 0) ? 0 : int'($urandom_range(0, 3));
         exp_busy += SK*SK + SL + 2 + stall;
         for (int s = 0; s <= stall; s++) begin
            n_cmp++;
            if ({s_ctl, s_orow, s_ocol} !== {8'b1000_0001, 2'(oy), 2'(ox)}) begin
               n_bad++; $display("FAIL small_write w=%0d: got %h want %h", w, {s_ctl, s_orow, s_ocol}, {8'b1000_0001, 2'(oy), 2'(ox)});
            end
            s_ready = (s == stall);
            busy_cnt += int'(s_busy); dones += int'(s_done);
            @(negedge clk);
         end
         s_ready = 1'b0;
      end
      n_cmp++;
      if ({s_busy, s_done, s_rd_en, s_valid} !== 4'b0100) begin
         n_bad++; $display("FAIL small_done: got %b want 0100", {s_busy, s_done, s_rd_en, s_valid});
      end
      dones += int'(s_done);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n_cmp++;
      if (s_ctl !== 8'd0) begin n_bad++; $display("FAIL start_on_done_ignored: got %b want 0", s_ctl); end
      n_cmp++;
      if (busy_cnt != exp_busy) begin n_bad++; $display("FAIL small_busy_cycles: got %0d want %0d", busy_cnt, exp_busy); end
      n_cmp++;
      if (dones != 1) begin n_bad++; $display("FAIL small_done_count: got %0d want 1", dones); end
   endtask

   task automatic test_idle_start_abort();
      int t;
      s_start = 1'b1; s_abort = 1'b1;
      @(negedge clk);
      s_start = 1'b0; s_abort = 1'b0;
      n_cmp++;
      if (s_ctl !== 8'd0) begin n_bad++; $display("FAIL start_abort_idle: got %b want 0", s_ctl); end
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      n_cmp++;
      if ({s_busy, s_rd_en, s_row, s_col, s_kidx} !== {1'b1, 1'b1, 12'd0}) begin
         n_bad++; $display("FAIL idle_start_accept: got %h want %h", {s_busy, s_rd_en, s_row, s_col, s_kidx}, {1'b1, 1'b1, 12'd0});
      end
      t = int'($urandom_range(0, 7));
      repeat (t) @(negedge clk);
      n_cmp++;
      if (s_kidx !== 4'(t)) begin n_bad++; $display("FAIL rand_abort_tap: got %0d want %0d", s_kidx, t); end
      s_abort = 1'b1;
      @(negedge clk);
      s_abort = 1'b0;
      n_cmp++;
      if (s_ctl !== 8'd0) begin n_bad++; $display("FAIL rand_abort_idle: got %b want 0", s_ctl); end
      repeat (3) @(negedge clk);
      n_cmp++;
      if (s_ctl !== 8'd0) begin n_bad++; $display("FAIL rand_abort_quiet: got %b want 0", s_ctl); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_first_window();
      test_backpressure();
      test_abort();
      test_restart_reset();
      test_small_full();
      test_idle_start_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no completion want finish before 900000");
      $fatal(1, "bench watchdog expired");
   end

endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
Sequential controller that time-multiplexes a single MAC datapath over the stride-4 11x11 conv2d layer (227x227 input to 55x55 output). It walks output positions in raster order and, for each one, walks the kernel taps in raster order. It issues input-buffer and kernel-ROM read addresses, drives the accumulator controls aligned to the read data, and hands each finished sum to the output buffer through a valid/ready handshake. It sits between the layer sequencer (start/done) and the buffer/MAC datapath.

Parameters:
IN_H, 227, input rows
IN_W, 227, input columns
K, 11, kernel side
STRIDE, 4, window step
OUT_H, 55, output rows; must satisfy (OUT_H-1)*STRIDE+K <= IN_H (elaboration assertion)
OUT_W, 55, output columns; same constraint against IN_W
RD_LAT, 1, input/kernel read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle start request; accepted only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle, no done
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last output handshake
in_rd_en  out  1  input buffer read strobe
in_rd_row  out  $clog2(IN_H)  oy*STRIDE+m
in_rd_col  out  $clog2(IN_W)  ox*STRIDE+n
k_rd_en  out  1  kernel read strobe, equal to in_rd_en
k_rd_idx  out  $clog2(K*K)  m*K+n
mac_en  out  1  product valid this cycle (in_rd_en delayed RD_LAT)
mac_clr  out  1  with mac_en: load product instead of accumulate (tap 0)
mac_last  out  1  with mac_en: final tap of the window
out_valid  out  1  accumulator result ready for the output buffer
out_ready  in  1  output buffer accepts
out_row  out  $clog2(OUT_H)  oy of the current result
out_col  out  $clog2(OUT_W)  ox of the current result

Behaviour:
- Reset: all outputs 0; state IDLE; counters oy, ox, m, n = 0; tap delay line cleared.
- States: IDLE, ISSUE, DRAIN, WRITE, DONE.
- IDLE: if start and not abort, go to ISSUE and clear oy, ox, m, n. A start while not in IDLE is ignored.
- ISSUE: in_rd_en = k_rd_en = 1 every cycle. Taps advance n, then m, in raster order.
  - At m=n=K-1, go to DRAIN. This gives exactly K*K issue cycles, 121 by default.
- Addresses: row/col bases (oy*STRIDE, ox*STRIDE) are held in registers and incremented by STRIDE. No multipliers are used. k_rd_idx is a counter that resets at each window.
- The tap delay line carries {valid, first, last} for RD_LAT stages. mac_en/mac_clr/mac_last appear exactly RD_LAT cycles after the matching issue.
- DRAIN: lasts RD_LAT+1 cycles, covering the delay-line flush plus the accumulator register. Then go to WRITE.
  - First out_valid occurs K*K+RD_LAT+1 cycles after the first ISSUE cycle.
- WRITE: out_valid=1 with stable out_row/out_col until out_ready. out_ready outside WRITE is ignored. On the handshake:
  - If ox<OUT_W-1: ox++ and go to ISSUE.
  - Else if oy<OUT_H-1: ox=0, oy++ and go to ISSUE.
  - Else go to DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- No overlap between windows. Per-output cost is K*K+RD_LAT+2 cycles plus backpressure wait.
- abort: has priority in every state. Next cycle state is IDLE, strobes, out_valid and the delay line are 0, and done is not pulsed.
- Reset mid-operation: immediate return to the reset state; no partial output is flagged.
- Simultaneous start and abort in IDLE: abort wins, so the block stays IDLE.
- Widths: address outputs are zero-extended counters. Bound checks guarantee no wrap. Counters must never exceed their terminal values.

Decomposition:
- Package conv_pkg: layer constants (IN_H, IN_W, K, STRIDE, OUT_H, OUT_W), derived address widths, and the state enum conv_state_e.
- Sub-module conv_tap_pipe: a parameterised RD_LAT-stage shift register of {valid, first, last} with clear on rst/abort. Reused later for the pooling controller.

Test Plan:
- Default params, RD_LAT=1, out_ready tied 1, one start:
  - 3025 out_valid handshakes in raster order; done exactly once.
  - Total busy cycles 3025*124.
  - First window addresses (0,0)..(10,10); last window rows/cols 216..226.
- Small params IN=11, K=3, STRIDE=4, OUT=3, RD_LAT=2:
  - mac_clr coincides with the first mac_en of each window; mac_last with the ninth.
  - Per-output cycle count is 13.
  - k_rd_idx runs 0..8 in each window.
- Backpressure: hold out_ready=0 for 20 cycles at output (0,1):
  - out_valid stays high with out_row=0, out_col=1 stable.
  - No in_rd_en while waiting.
  - Issue resumes the cycle after the handshake.
- Abort mid-ISSUE of output (2,5) tap 37:
  - Next cycle is IDLE; all strobes 0; no done.
  - A fresh start restarts from (0,0).
- Start pulsed during ISSUE and in the same cycle as done: both ignored; a start in IDLE afterwards is accepted normally.
- Asynchronous rst asserted mid-DRAIN, between clock edges: all outputs read 0 before the next edge and the block stays IDLE after release.
